// File: rtl/apb_sram_slave_pkg.sv
// Shared types for the APB SRAM slave: FSM states, error response value and
// the address-decode helper.
package apb_sram_slave_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam logic [31:0] APB_ERR_RDATA = 32'h0000_0000;

  // Misaligned, or outside [base, base+span); 33-bit sum avoids wrap at the top of the map
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] span);
    return (addr[1:0] != 2'b00) || (addr < base) ||
           ({1'b0, addr} >= ({1'b0, base} + span));
  endfunction

endpackage

// File: rtl/apb_sram_slave_sram_1rw.sv
// Single-port SRAM with per-byte write enables and a registered read port.
// Each byte lane is its own array so it maps directly onto block RAM.
module sram_1rw #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rdata_reg;

      always_ff @(posedge clk) begin
        if (en && we && be[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
        if (en && !we) begin
          lane_rdata_reg <= lane_mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = lane_rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/apb_sram_slave.sv
// APB3 slave in front of a byte-writable SRAM with programmable wait states.
// Reads are fetched at the setup edge; writes commit on the pready edge.
module apb_sram_slave
  import apb_sram_slave_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  apb_state_e    state_reg, state_next;
  logic [3:0]    cnt_reg;
  logic [AW-1:0] addr_reg;
  logic          wr_reg;
  logic          err_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    strb_reg;
  logic [31:0]   prdata_reg, prdata_next;

  logic          setup_err;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  // BASE_ADDR is span-aligned, so the word index is just the low address bits
  assign setup_err = addr_err(paddr, BASE_ADDR, SPAN);

  always_comb begin
    state_next  = state_reg;
    pready      = 1'b0;
    pslverr     = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_reg;
    prdata_next = prdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (psel && penable) begin
          pready  = 1'b1;
          pslverr = 1'b1;
          if (!pwrite) prdata_next = APB_ERR_RDATA;
        end else if (psel) begin
          state_next = ST_ACCESS;
          ram_addr   = paddr[AW+1:2];
          ram_en     = !pwrite && !setup_err;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_next = ST_IDLE;
        end else if (penable && (cnt_reg == 4'd0)) begin
          pready     = 1'b1;
          pslverr    = err_reg;
          state_next = ST_IDLE;
          if (wr_reg) begin
            ram_en = !err_reg;
            ram_we = !err_reg;
          end else begin
            prdata_next = err_reg ? APB_ERR_RDATA : ram_rdata;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Reset suppresses any response or memory write in the same cycle
    if (rst) begin
      pready      = 1'b0;
      pslverr     = 1'b0;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      prdata_next = 32'h0;
    end
  end

  assign prdata = prdata_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      addr_reg   <= '0;
      wr_reg     <= 1'b0;
      err_reg    <= 1'b0;
      wdata_reg  <= 32'h0;
      strb_reg   <= 4'h0;
      prdata_reg <= 32'h0;
    end else begin
      state_reg  <= state_next;
      prdata_reg <= prdata_next;
      if (state_reg == ST_IDLE && psel && !penable) begin
        cnt_reg   <= 4'(WAIT_CYCLES);
        addr_reg  <= paddr[AW+1:2];
        wr_reg    <= pwrite;
        err_reg   <= setup_err;
        wdata_reg <= pwdata;
        strb_reg  <= pstrb;
      end else if (state_reg == ST_ACCESS && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  sram_1rw #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_sram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .be   (strb_reg),
    .wdata(wdata_reg),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_apb_sram_slave.sv
// Scoreboard bench: three slaves (WAIT_CYCLES 1, 0, 3) share one APB bus,
// each with its own psel; a negedge monitor checks every pready response.
module tb_apb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  psel_v = 3'b000;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic [31:0] prdata_w [3];
  logic [2:0]  pready_w;
  logic [2:0]  pslverr_w;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int sel = 0;

  typedef struct {
    logic [31:0] d;
    bit          e;
    bit          wr;
    int          c;
  } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]));

  apb_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]));

  apb_sram_slave #(.DEPTH(64), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_w[2]), .pready(pready_w[2]), .pslverr(pslverr_w[2]));

  // Monitor: pops one expectation per pready of the selected slave
  always @(negedge clk) begin
    if (!rst) begin
      if (pready_w[sel]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pready inst=%0d cyc=%0d", sel, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (pslverr_w[sel] !== e.e || cyc != e.c || (!e.wr && prdata_w[sel] !== e.d)) begin
            miscompares++;
            $display("FAIL response inst=%0d got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                     sel, prdata_w[sel], pslverr_w[sel], cyc, e.d, e.e, e.c);
          end
        end
      end else begin
        vectors++;
        if (pslverr_w[sel] !== 1'b0) begin
          miscompares++;
          $display("FAIL slverr_without_ready inst=%0d got %b want 0", sel, pslverr_w[sel]);
        end
      end
    end
  end

  task automatic drive_setup(input int inst, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
    sel     = inst;
    psel_v  = 3'b000;
    psel_v[inst] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
  endtask

  // Called just after a rising edge; returns just after the completing edge
  task automatic xfer(input int inst, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp_d, input bit exp_e, input int lat);
    exp_t e;
    bit done;
    int n;
    drive_setup(inst, wr, addr, data, strb);
    e.d = exp_d; e.e = exp_e; e.wr = wr; e.c = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = ~addr;
    pwdata  = ~data;
    pstrb   = ~strb;
    pwrite  = ~wr;
    done = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (pready_w[inst]) done = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout inst=%0d addr=%h got no pready want pready", inst, addr);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    psel_v  = 3'b000;
    penable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_pready",  {31'h0, pready_w[i]},  32'h0);
      check("reset_pslverr", {31'h0, pslverr_w[i]}, 32'h0);
      check("reset_prdata",  prdata_w[i],           32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // WAIT_CYCLES=1: pready two cycles after setup
    xfer(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 2);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2);
    xfer(0, 1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 0, 2);
    xfer(0, 1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 0, 2);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 0, 2);
    xfer(0, 1, 32'h00, 32'h1234_5678, 4'hF, 32'h0, 0, 2);
    // Error accesses: misaligned and one past the top
    xfer(0, 0, 32'h02, 32'h0, 4'h0, 32'h0, 1, 2);
    xfer(0, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1, 2);
    xfer(0, 1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 2);
    xfer(0, 1, 32'h11, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 2);
    xfer(0, 0, 32'h00, 32'h0, 4'h0, 32'h1234_5678, 0, 2);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 0, 2);
    bus_idle();

    // Protocol violation: penable together with psel in IDLE
    begin
      exp_t e;
      drive_setup(0, 0, 32'h10, 32'h0, 4'h0);
      penable = 1'b1;
      e.d = 32'h0; e.e = 1; e.wr = 0; e.c = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus_idle();
    end
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2);
    bus_idle();

    // WAIT_CYCLES=0 back-to-back
    xfer(1, 1, 32'h0, 32'd1, 4'hF, 32'h0, 0, 1);
    xfer(1, 1, 32'h4, 32'd2, 4'hF, 32'h0, 0, 1);
    xfer(1, 1, 32'h8, 32'd3, 4'hF, 32'h0, 0, 1);
    xfer(1, 0, 32'h0, 32'h0, 4'h0, 32'd1, 0, 1);
    xfer(1, 0, 32'h4, 32'h0, 4'h0, 32'd2, 0, 1);
    xfer(1, 0, 32'h8, 32'h0, 4'h0, 32'd3, 0, 1);
    bus_idle();

    // Reset during the first access cycle of a write
    xfer(0, 1, 32'h8, 32'h5, 4'hF, 32'h0, 0, 2);
    drive_setup(0, 1, 32'h8, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pready", {31'h0, pready_w[0]}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    psel_v  = 3'b000;
    penable = 1'b0;
    check("rst_mid_prdata", prdata_w[0], 32'h0);
    @(posedge clk); #1;
    xfer(0, 0, 32'h8, 32'h0, 4'h0, 32'h5, 0, 2);
    bus_idle();

    // WAIT_CYCLES=3, nonzero base, aborted transfer
    xfer(2, 1, 32'h0001_0004, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 4);
    drive_setup(2, 1, 32'h0001_0004, 32'h0000_0BAD, 4'hF);
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel_v  = 3'b000;
    penable = 1'b0;
    @(posedge clk); #1;
    xfer(2, 0, 32'h0001_0004, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 4);
    xfer(2, 0, 32'h0000_0004, 32'h0, 4'h0, 32'h0, 1, 4);
    xfer(2, 0, 32'h0001_0100, 32'h0, 4'h0, 32'h0, 1, 4);
    bus_idle();
    repeat (3) @(posedge clk);

    check("queue_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_sram_slave.md
APB_SRAM_SLAVE -- requirements
Module: apb_sram_slave

Interface
REQ-001 Parameter DEPTH, default 1024, memory size in 32-bit words (power of two, >=4).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (DEPTH*4 aligned).
REQ-003 Parameter WAIT_CYCLES, default 1, wait states inserted per access (0..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 apb  apb_if.slave  --  APB port carrying the signals REQ-007..REQ-015.
REQ-007 psel  input  1  slave selected.
REQ-008 penable  input  1  access phase.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 paddr  input  32  byte address.
REQ-011 pwdata  input  32  write data.
REQ-012 pstrb  input  4  byte-lane write strobes; lane i = pwdata[8i+7:8i].
REQ-013 prdata  output  32  read data, valid when pready=1.
REQ-014 pready  output  1  transfer completes this cycle.
REQ-015 pslverr  output  1  transfer error, valid only when pready=1.

Function
REQ-016 The FSM SHALL have states IDLE and ACCESS.
REQ-017 In IDLE, psel=1 and penable=0 (setup) SHALL latch paddr, pwrite, pwdata and pstrb, load the wait counter with WAIT_CYCLES, and move to ACCESS next cycle.
REQ-018 An access SHALL be in error when paddr[1:0]!=0 or paddr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
REQ-019 For a non-error read, prdata SHALL be registered at the setup edge from mem[(paddr-BASE_ADDR)>>2] and held stable through ACCESS.
REQ-020 In ACCESS, pready SHALL equal (penable && counter==0) combinationally; the counter SHALL decrement by 1 per cycle while nonzero.
REQ-021 Latency from setup cycle to pready=1 SHALL be exactly WAIT_CYCLES+1 cycles (WAIT_CYCLES=0: pready in first access cycle).
REQ-022 A non-error write SHALL update only the lanes with pstrb[i]=1, at the clock edge where pready=1; other lanes SHALL remain unchanged.
REQ-023 On an error access, pslverr SHALL be 1 with pready, the memory SHALL NOT be written, and prdata SHALL read 32'h0.
REQ-024 pslverr SHALL be 0 whenever pready=0.
REQ-025 After pready=1, the FSM SHALL return to IDLE; a new setup in the next cycle SHALL be accepted (back-to-back, one idle-free setup cycle per transfer).
REQ-026 If psel drops while in ACCESS before pready, the transfer SHALL be aborted: return to IDLE, no write, pready stays 0.
REQ-027 penable=1 with psel=1 while in IDLE (protocol violation) SHALL produce pready=1 and pslverr=1 in that cycle with no memory effect.
REQ-028 Changes to paddr/pwdata/pstrb/pwrite during ACCESS SHALL be ignored (latched values used).
REQ-029 A read following a write to the same word SHALL return the written data (no stale read).
REQ-030 prdata SHALL be held at its last value outside completing read transfers.

Reset
REQ-031 While rst=1, FSM SHALL go to IDLE, counter to 0, prdata to 32'h0, pready and pslverr to 0.
REQ-032 rst asserted mid-transfer SHALL abort it with no memory write; memory contents SHALL NOT be cleared by reset.
REQ-033 The first setup SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-034 The APB state enum (IDLE, ACCESS) and the APB error-response constant SHALL live in the shared typedefs package.
REQ-035 The storage array SHALL be one sub-module, sram_1rw (one port, byte-write-enable, registered read), so it can be swapped for a macro.
REQ-036 The block SHALL be usable as imem or dmem backing store behind the core's APB masters without modification.

Verification
REQ-037 WAIT_CYCLES=1: write 32'hDEAD_BEEF to 0x10 with pstrb=4'hF, then read 0x10 -> pready in 2nd access cycle each time, prdata=32'hDEAD_BEEF, pslverr=0.
REQ-038 Word 0x20 = 32'h1122_3344, write 32'hAABB_CCDD with pstrb=4'b0101 -> read returns 32'h11BB_33DD.
REQ-039 Read 0x02 (misaligned) and read BASE_ADDR+4*DEPTH -> pready=1, pslverr=1, prdata=0; a write to the out-of-range address leaves all memory unchanged.
REQ-040 WAIT_CYCLES=0, back-to-back writes to 0x0,0x4,0x8 then reads -> each transfer takes 2 cycles (setup+access), data 1,2,3 returned.
REQ-041 Assert rst in the 1st ACCESS cycle of a write of 32'hFFFF_FFFF to 0x8 holding 32'h5 -> pready=0, subsequent read of 0x8 returns 32'h5.
REQ-042 Drop psel mid-ACCESS with WAIT_CYCLES=3 -> no pready, no write; next setup completes normally after 4 cycles.
